// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-bit adder with handshake and two-digit multiplexed hex display
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [6:0] seg,
  output logic [1:0] digit_en,
  output logic       over,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ADD, SHOW} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SCAN_DIV - 1);

  state_t     state, state_n;
  logic [3:0] op_a, op_b, op_a_n, op_b_n;
  logic [4:0] sum, sum_n;
  logic [7:0] cnt, cnt_n;
  logic       hi, hi_n;
  logic       on, on_n;
  logic [6:0] seg_n;
  logic [1:0] digit_en_n;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    sum_n   = sum;
    cnt_n   = cnt;
    hi_n    = hi;
    on_n    = on;

    // Scanning keeps running while a result is on display, including ADD entered from SHOW
    if (on) begin
      if (cnt == CNT_LAST) begin
        cnt_n = '0;
        hi_n  = ~hi;
      end else begin
        cnt_n = cnt + 8'd1;
      end
    end

    case (state)
      IDLE, SHOW: begin
        if (in_valid) begin
          state_n = ADD;
          op_a_n  = a;
          op_b_n  = b;
        end
      end
      ADD: begin
        sum_n   = {1'b0, op_a} + {1'b0, op_b};
        state_n = SHOW;
        if (!on) begin
          on_n  = 1'b1;
          cnt_n = '0;
          hi_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    digit_en_n = !on_n ? 2'b00 : (hi_n ? 2'b10 : 2'b01);
    seg_n      = !on_n ? 7'b0000000 : glyph(hi_n ? {3'b000, sum_n[4]} : sum_n[3:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      sum      <= '0;
      cnt      <= '0;
      hi       <= 1'b0;
      on       <= 1'b0;
      seg      <= '0;
      digit_en <= 2'b00;
      over     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      sum      <= sum_n;
      cnt      <= cnt_n;
      hi       <= hi_n;
      on       <= on_n;
      seg      <= seg_n;
      digit_en <= digit_en_n;
      over     <= sum_n[4];
      busy     <= (state_n == ADD);
      in_ready <= (state_n != ADD);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       in_ready, over, busy;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       in_ready1, over1, busy1;
  logic [6:0] seg1;
  logic [1:0] digit_en1;

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q[$];
  logic [4:0] cur = '0;
  logic       cur_valid = 1'b0;
  logic       prev_busy = 1'b0;
  logic       accepted = 1'b0;

  seg_scan_ctrl #(.SCAN_DIV(4)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .seg(seg), .digit_en(digit_en), .over(over), .busy(busy)
  );

  seg_scan_ctrl #(.SCAN_DIV(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .seg(seg1), .digit_en(digit_en1), .over(over1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'h0: ref_glyph = 7'b0111111;
      4'h1: ref_glyph = 7'b0000110;
      4'h2: ref_glyph = 7'b1011011;
      4'h3: ref_glyph = 7'b1001111;
      4'h4: ref_glyph = 7'b1100110;
      4'h5: ref_glyph = 7'b1101101;
      4'h6: ref_glyph = 7'b1111101;
      4'h7: ref_glyph = 7'b0000111;
      4'h8: ref_glyph = 7'b1111111;
      4'h9: ref_glyph = 7'b1101111;
      4'hA: ref_glyph = 7'b1110111;
      4'hB: ref_glyph = 7'b1111100;
      4'hC: ref_glyph = 7'b0111001;
      4'hD: ref_glyph = 7'b1011110;
      4'hE: ref_glyph = 7'b1111001;
      default: ref_glyph = 7'b1110001;
    endcase
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: picks up each completed result and checks every displayed cycle against it
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_valid = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) check_eq("unexpected_result", 32'd1, 32'd0);
        else begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
        end
      end
      check_eq("digit_en_not_11", 32'(digit_en != 2'b11), 32'd1);
      if (digit_en == 2'b00) check_eq("blank_seg", 32'(seg), 32'd0);
      else if (!cur_valid) check_eq("display_without_result", 32'(digit_en), 32'd0);
      else begin
        check_eq("seg_digit", 32'(seg), 32'(ref_glyph(digit_en[1] ? {3'b000, cur[4]} : cur[3:0])));
        check_eq("over", 32'(over), 32'(cur[4]));
      end
      prev_busy = busy;
    end
  end

  // Called at posedge+1; consumes one cycle and returns at the next posedge+1
  task automatic drive_cycle(input logic [3:0] va, input logic [3:0] vb, input logic v,
                             input logic [4:0] exp);
    a = va;
    b = vb;
    in_valid = v;
    @(negedge clk);
    accepted = v && in_ready;
    if (accepted) exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic [4:0] exp);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(va, vb, 1'b1, exp);
      if (accepted) break;
    end
    in_valid = 1'b0;
    check_eq("accept", 32'(accepted), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(4'd0, 4'd0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_over"}, 32'(over), 32'd0);
    check_eq({tag, "_seg"}, 32'(seg), 32'd0);
    check_eq({tag, "_digit_en"}, 32'(digit_en), 32'd0);
  endtask

  initial begin
    logic [3:0] va, vb;

    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // 3 + 4 from IDLE: one busy cycle, then 7 on the low digit and scanning
    drive_cycle(4'd3, 4'd4, 1'b1, 5'd7);
    in_valid = 1'b0;
    check_eq("accept_first", 32'(accepted), 32'd1);
    @(negedge clk);
    check_eq("add_busy", 32'(busy), 32'd1);
    check_eq("add_in_ready", 32'(in_ready), 32'd0);
    check_eq("add_blank", 32'(digit_en), 32'd0);
    @(negedge clk);
    check_eq("show_busy", 32'(busy), 32'd0);
    check_eq("show_seg_7", 32'(seg), 32'b0000111);
    check_eq("show_over_0", 32'(over), 32'd0);
    for (int i = 0; i < 16; i++) begin
      check_eq("scan4_digit_en", 32'(digit_en), (i % 8 < 4) ? 32'd1 : 32'd2);
      check_eq("scan1_digit_en", 32'(digit_en1), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("scan1_seg", 32'(seg1), (i % 2 == 0) ? 32'b0000111 : 32'b0111111);
      check_eq("scan1_in_ready", 32'(in_ready1), 32'(in_ready));
      check_eq("scan1_busy", 32'(busy1), 32'(busy));
      check_eq("scan1_over", 32'(over1), 32'(over));
      if (i == 4) check_eq("high_seg_0", 32'(seg), 32'b0111111);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // 15 + 15 = 0x1E from SHOW
    send(4'd15, 4'd15, 5'h1E);
    @(negedge clk);
    check_eq("add_from_show_digit_en", 32'(digit_en != 2'b00), 32'd1);
    @(negedge clk);
    check_eq("over_1", 32'(over), 32'd1);
    @(posedge clk);
    #1;
    idle(9);

    // in_valid held high: every other pair is accepted
    for (int k = 0; k < 12; k++) begin
      va = 4'(k * 5 + 1);
      vb = 4'(k * 7 + 2);
      drive_cycle(va, vb, 1'b1, 5'(va) + 5'(vb));
      check_eq("in_ready_alternate", 32'(accepted), 32'(k % 2 == 0));
    end
    in_valid = 1'b0;
    idle(8);

    // Full operand sweep
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        send(4'(ai), 4'(bi), 5'(ai) + 5'(bi));
        idle(7);
      end
    end

    // Reset during ADD
    send(4'd5, 4'd6, 5'd11);
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_in_add");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_cycle(4'd2, 4'd2, 1'b1, 5'd4);
    in_valid = 1'b0;
    check_eq("accept_after_release", 32'(accepted), 32'd1);
    @(negedge clk);
    check_eq("blank_after_reset", 32'(digit_en), 32'd0);
    @(posedge clk);
    #1;
    idle(6);

    // Reset during SHOW
    idle(3);
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset_in_show");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    send(4'd9, 4'd8, 5'd17);
    idle(6);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
